// File: rtl/fixed_to_float_conv_pkg.sv
// Shared float-format constants and FSM state encoding for the fixed-to-float converter.
package fixed_to_float_conv_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_IW   = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_lead_zero_cnt.sv
// Combinational leading-zero counter; an all-zero input reports W-1.
module fp_lead_zero_cnt #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]         in,
  output logic [$clog2(W)-1:0] cnt
);

  localparam int unsigned CW = $clog2(W);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    cnt = CW'(W - 1);
    for (int unsigned i = 0; i < W; i++) begin
      if (in[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fixed_to_float_conv.sv
// Signed fixed-point to IEEE-754 single converter with valid/ready on both sides.
// Optional FIX2FLT_FAST_NORM_EN: single-cycle normalization via leading-zero count.
module fixed_to_float_conv
  import fixed_to_float_conv_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned FRAC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  localparam int unsigned EXP_INIT = EXP_BIAS + IN_W - 1 - FRAC_W;

  state_t              r_state;
  logic                r_sign;
  logic [IN_W-1:0]     r_mag;
  logic [EXP_IW-1:0]   r_exp;
  logic [31:0]         r_out_data;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_busy;

  logic [IN_W-1:0]     w_abs;
  logic [IN_W-1:0]     w_norm_mag;
  logic [EXP_IW-1:0]   w_norm_exp;
  logic                w_norm_ok;
  logic                w_is_zero;
  logic [IN_W+22:0]    w_mant_wide;
  logic [MANT_W-1:0]   w_mant;
  logic [31:0]         w_result;

  // Most negative input maps to 2^(IN_W-1), which still fits unsigned in IN_W bits.
  assign w_abs = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

`ifdef FIX2FLT_FAST_NORM_EN
  localparam int unsigned LZC_W = $clog2(IN_W);
  logic [LZC_W-1:0] w_lzc;

  fp_lead_zero_cnt #(.W(IN_W)) u_lzc (
    .in  (r_mag),
    .cnt (w_lzc)
  );

  assign w_norm_mag = r_mag << w_lzc;
  assign w_norm_exp = r_exp - EXP_IW'(w_lzc);
`else
  assign w_norm_mag = r_mag;
  assign w_norm_exp = r_exp;
`endif

  assign w_norm_ok   = w_norm_mag[IN_W-1];
  assign w_is_zero   = (r_mag == '0);
  // Drop the hidden bit and left-justify the fraction into 23 mantissa bits.
  assign w_mant_wide = {w_norm_mag[IN_W-2:0], 24'b0} >> IN_W;
  assign w_mant      = MANT_W'(w_mant_wide);
  assign w_result    = {r_sign, EXP_W'(w_norm_exp), w_mant};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_exp       <= '0;
      r_out_data  <= 32'h0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign     <= in_data[IN_W-1];
            r_mag      <= w_abs;
            r_exp      <= EXP_IW'(EXP_INIT);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_NORM;
          end
        end
        ST_NORM: begin
          if (w_is_zero) begin
            r_out_data <= 32'h0;
            r_state    <= ST_DONE;
          end else if (w_norm_ok) begin
            r_out_data <= w_result;
            r_state    <= ST_DONE;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - EXP_IW'(1);
          end
        end
        ST_DONE: begin
          // First DONE cycle raises valid; result is then held until accepted.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
